// File: rtl/hidden_layer_sequencer_pkg.sv
// Shared types and default sizing for the hidden-layer sequencer and datapath.
// Optional HL_SEQ_CYCLE_CNT_EN adds a run-length cycle counter.
package nn_pkg;

  localparam int DEF_N_INPUTS  = 62;
  localparam int DEF_N_NEURONS = 20;
  localparam int DEF_MEM_LAT   = 1;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW = cw(DEF_N_NEURONS * DEF_N_INPUTS);
  localparam int IW = cw(DEF_N_INPUTS);
  localparam int NW = cw(DEF_N_NEURONS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    DRAIN,
    BIAS,
    ACT,
    STORE,
    FIN
  } hl_state_e;

endpackage

// File: rtl/hidden_layer_sequencer_if.sv
// Control bundle between sequencer, datapath, weight ROM and top handshake.
// cycle_cnt exists only when HL_SEQ_CYCLE_CNT_EN is defined.
interface hidden_layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int A_W = AW,
  parameter int I_W = IW,
  parameter int N_W = NW
);

  logic           start;
  logic [A_W-1:0] w_addr;
  logic [I_W-1:0] in_sel;
  logic           acc_clr;
  logic           acc_en;
  logic           bias_en;
  logic           act_en;
  logic           out_we;
  logic [N_W-1:0] out_addr;
  logic           busy;
  logic           done;
`ifdef HL_SEQ_CYCLE_CNT_EN
  logic [15:0]    cycle_cnt;
`endif

  modport master (
`ifdef HL_SEQ_CYCLE_CNT_EN
    output cycle_cnt,
`endif
    input  start,
    output w_addr,
    output in_sel,
    output acc_clr,
    output acc_en,
    output bias_en,
    output act_en,
    output out_we,
    output out_addr,
    output busy,
    output done
  );

  modport slave (
`ifdef HL_SEQ_CYCLE_CNT_EN
    input  cycle_cnt,
`endif
    output start,
    input  w_addr,
    input  in_sel,
    input  acc_clr,
    input  acc_en,
    input  bias_en,
    input  act_en,
    input  out_we,
    input  out_addr,
    input  busy,
    input  done
  );

endinterface

// File: rtl/hidden_layer_sequencer_valid_pipe.sv
// Issue-valid delay line matching the weight ROM read latency.
// Its output lines up acc_en with the ROM data for each issued address.
module hl_seq_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_v,
  output logic out_v
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(in_v);
    end
  end

  assign out_v = sr[DEPTH-1];

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Sequences one shared MAC datapath over every hidden-layer neuron.
// HL_SEQ_CYCLE_CNT_EN adds cycle_cnt (length of the last run).
module hidden_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  hidden_layer_sequencer_if.master bus
);

  localparam int A_W = cw(N_NEURONS * N_INPUTS);
  localparam int I_W = cw(N_INPUTS);
  localparam int N_W = cw(N_NEURONS);
  localparam int D_W = cw(MEM_LAT);

  localparam logic [I_W-1:0] I_LAST = I_W'(N_INPUTS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(N_NEURONS - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(MEM_LAT - 1);

  hl_state_e      state;
  hl_state_e      state_nx;
  logic [I_W-1:0] idx;
  logic [N_W-1:0] nrn;
  logic [A_W-1:0] addr;
  logic [D_W-1:0] dcnt;
  logic           issue;
  logic           accept;

  assign accept = (state == IDLE) && bus.start;
  assign issue  = (state == MAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = CLEAR;
      CLEAR:   state_nx = MAC;
      MAC:     if (idx == I_LAST) state_nx = DRAIN;
      DRAIN:   if (dcnt == D_LAST) state_nx = BIAS;
      BIAS:    state_nx = ACT;
      ACT:     state_nx = STORE;
      STORE:   state_nx = (nrn == N_LAST) ? FIN : CLEAR;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // addr is a running counter: it holds the last address between
  // neurons and steps once more on CLEAR, so no n*N_INPUTS is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      nrn  <= '0;
      addr <= '0;
      dcnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) nrn <= '0;
        end
        CLEAR: begin
          idx  <= '0;
          addr <= (nrn == '0) ? '0 : addr + A_W'(1);
        end
        MAC: begin
          dcnt <= '0;
          if (idx != I_LAST) begin
            idx  <= idx + I_W'(1);
            addr <= addr + A_W'(1);
          end
        end
        DRAIN: begin
          dcnt <= dcnt + D_W'(1);
        end
        STORE: begin
          if (nrn != N_LAST) nrn <= nrn + N_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  hl_seq_valid_pipe #(
    .DEPTH (MEM_LAT)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_v  (issue),
    .out_v (bus.acc_en)
  );

  assign bus.w_addr   = addr;
  assign bus.in_sel   = idx;
  assign bus.out_addr = nrn;
  assign bus.acc_clr  = (state == CLEAR);
  assign bus.bias_en  = (state == BIAS);
  assign bus.act_en   = (state == ACT);
  assign bus.out_we   = (state == STORE);
  assign bus.done     = (state == FIN);
  assign bus.busy     = (state != IDLE) && (state != FIN);

`ifdef HL_SEQ_CYCLE_CNT_EN
  logic [15:0] ccnt;

  // The accepting cycle is counted, so the value equals start->done latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccnt <= '0;
    end else if (accept) begin
      ccnt <= 16'd1;
    end else if (bus.busy && ccnt != 16'hFFFF) begin
      ccnt <= ccnt + 16'd1;
    end
  end

  assign bus.cycle_cnt = ccnt;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Self-checking bench for hidden_layer_sequencer (MEM_LAT 1 and 3 instances).
// Expected strobes come from a per-cycle schedule derived from the layer timing rules.
module tb_hidden_layer_sequencer;

  localparam int NI = 62;
  localparam int NN = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  bit   sel_b  = 1'b0;

  hidden_layer_sequencer_if bus_a ();
  hidden_layer_sequencer_if bus_b ();

  hidden_layer_sequencer #(.MEM_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  hidden_layer_sequencer #(.MEM_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // strobes packed {acc_clr, acc_en, bias_en, act_en, out_we, busy, done}
  logic [6:0]  o_str;
  logic [10:0] o_wa;
  logic [5:0]  o_is;
  logic [4:0]  o_oa;
  logic [15:0] o_cc;

  always_comb begin
    if (sel_b) begin
      o_str = {bus_b.acc_clr, bus_b.acc_en, bus_b.bias_en, bus_b.act_en,
               bus_b.out_we, bus_b.busy, bus_b.done};
      o_wa  = bus_b.w_addr;
      o_is  = bus_b.in_sel;
      o_oa  = bus_b.out_addr;
    end else begin
      o_str = {bus_a.acc_clr, bus_a.acc_en, bus_a.bias_en, bus_a.act_en,
               bus_a.out_we, bus_a.busy, bus_a.done};
      o_wa  = bus_a.w_addr;
      o_is  = bus_a.in_sel;
      o_oa  = bus_a.out_addr;
    end
`ifdef HL_SEQ_CYCLE_CNT_EN
    o_cc = sel_b ? bus_b.cycle_cnt : bus_a.cycle_cnt;
`else
    o_cc = 16'd0;
`endif
  end

  typedef struct {
    logic [6:0] str;
    bit         issue;
    int         is;
    int         wa;
    int         oa;
  } exp_t;

  // Schedule for cycle k after the start-accepting cycle (k=1 is CLEAR of neuron 0).
  function automatic exp_t model(int k, int ml);
    exp_t e;
    int   p;
    int   n;
    int   j;
    e = '{default: 0};
    p = NI + ml + 4;
    if (k >= 1 && k <= NN * p) begin
      n      = (k - 1) / p;
      j      = (k - 1) % p;
      e.oa   = n;
      e.str[1] = 1'b1;
      if (j == 0) e.str[6] = 1'b1;
      if (j >= 1 && j <= NI) begin
        e.issue = 1'b1;
        e.is    = j - 1;
        e.wa    = n * NI + j - 1;
      end
      if (j >= ml + 1 && j <= NI + ml) e.str[5] = 1'b1;
      if (j == NI + ml + 1) e.str[4] = 1'b1;
      if (j == NI + ml + 2) e.str[3] = 1'b1;
      if (j == NI + ml + 3) e.str[2] = 1'b1;
    end else if (k == NN * p + 1) begin
      e.str[0] = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    checks++;
    if ({bus_a.acc_clr, bus_a.acc_en, bus_a.bias_en, bus_a.act_en,
         bus_a.out_we, bus_a.busy, bus_a.done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_strobes_a got %b want 0", {bus_a.acc_clr,
               bus_a.acc_en, bus_a.bias_en, bus_a.act_en, bus_a.out_we,
               bus_a.busy, bus_a.done});
    end
    checks++;
    if ({bus_a.w_addr, bus_a.in_sel, bus_a.out_addr} !== 22'd0) begin
      errors++;
      $display("FAIL reset_idx_a got %h want 0",
               {bus_a.w_addr, bus_a.in_sel, bus_a.out_addr});
    end
    checks++;
    if ({bus_b.acc_clr, bus_b.acc_en, bus_b.bias_en, bus_b.act_en,
         bus_b.out_we, bus_b.busy, bus_b.done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_strobes_b got %b want 0", {bus_b.acc_clr,
               bus_b.acc_en, bus_b.bias_en, bus_b.act_en, bus_b.out_we,
               bus_b.busy, bus_b.done});
    end
    checks++;
    if ({bus_b.w_addr, bus_b.in_sel, bus_b.out_addr} !== 22'd0) begin
      errors++;
      $display("FAIL reset_idx_b got %h want 0",
               {bus_b.w_addr, bus_b.in_sel, bus_b.out_addr});
    end
`ifdef HL_SEQ_CYCLE_CNT_EN
    checks++;
    if (bus_a.cycle_cnt !== 16'd0 || bus_b.cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cycle_cnt got %0d/%0d want 0",
               bus_a.cycle_cnt, bus_b.cycle_cnt);
    end
`endif
  endtask

  task automatic test_full_run();
    exp_t e;
    int   n_we    = 0;
    int   n_en    = 0;
    int   last_wa = -1;
    int   wa_err  = 0;
    int   done_k  = 0;
    sel_b = 1'b0;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= NN * 67 + 4; k++) begin
      @(negedge clk);
      if (k == 1) bus_a.start = 1'b0;
      e = model(k, 1);
      checks++;
      if (o_str !== e.str) begin
        errors++;
        $display("FAIL run_strobes k=%0d got %b want %b", k, o_str, e.str);
      end
      if (e.str[1]) begin
        checks++;
        if (o_oa !== 5'(e.oa)) begin
          errors++;
          $display("FAIL run_out_addr k=%0d got %0d want %0d", k, o_oa, e.oa);
        end
      end
      if (e.issue) begin
        checks++;
        if (o_is !== 6'(e.is) || o_wa !== 11'(e.wa)) begin
          errors++;
          $display("FAIL run_addr k=%0d got %0d/%0d want %0d/%0d",
                   k, o_wa, o_is, e.wa, e.is);
        end
        if (int'(o_wa) != last_wa + 1) wa_err++;
        last_wa = int'(o_wa);
      end
      if (o_str[2] === 1'b1) n_we++;
      if (o_str[5] === 1'b1) n_en++;
      if (o_str[0] === 1'b1 && done_k == 0) done_k = k;
`ifdef HL_SEQ_CYCLE_CNT_EN
      if (k == NN * 67 + 1 || k == NN * 67 + 4) begin
        checks++;
        if (o_cc !== 16'd1341) begin
          errors++;
          $display("FAIL run_cycle_cnt k=%0d got %0d want 1341", k, o_cc);
        end
      end
`endif
    end
    checks++;
    if (done_k != 1341) begin
      errors++;
      $display("FAIL run_latency got %0d want 1341", done_k);
    end
    checks++;
    if (n_we != NN || n_en != NN * NI) begin
      errors++;
      $display("FAIL run_counts got we=%0d en=%0d want 20/1240", n_we, n_en);
    end
    checks++;
    if (wa_err != 0 || last_wa != NN * NI - 1) begin
      errors++;
      $display("FAIL run_w_addr_seq got gaps=%0d last=%0d want 0/1239",
               wa_err, last_wa);
    end
  endtask

  task automatic test_mem_lat3();
    exp_t e;
    int   n_en   = 0;
    int   done_k = 0;
    sel_b = 1'b1;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    bus_b.start = 1'b1;
    for (int k = 1; k <= NN * 69 + 3; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.start = 1'b0;
      e = model(k, 3);
      checks++;
      if (o_str !== e.str) begin
        errors++;
        $display("FAIL lat3_strobes k=%0d got %b want %b", k, o_str, e.str);
      end
      if (e.issue) begin
        checks++;
        if (o_wa !== 11'(e.wa)) begin
          errors++;
          $display("FAIL lat3_w_addr k=%0d got %0d want %0d", k, o_wa, e.wa);
        end
      end
      if (o_str[5] === 1'b1) n_en++;
      if (o_str[0] === 1'b1 && done_k == 0) done_k = k;
    end
    checks++;
    if (done_k != 1381 || n_en != NN * NI) begin
      errors++;
      $display("FAIL lat3_done got k=%0d en=%0d want 1381/1240", done_k, n_en);
    end
`ifdef HL_SEQ_CYCLE_CNT_EN
    checks++;
    if (o_cc !== 16'd1381) begin
      errors++;
      $display("FAIL lat3_cycle_cnt got %0d want 1381", o_cc);
    end
`endif
    sel_b = 1'b0;
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int   extra  = $urandom_range(20, 1300);
    int   n_done = 0;
    sel_b = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= 1346; k++) begin
      @(negedge clk);
      bus_a.start = (k == 10 || k == 500 || k == extra || k == 1341);
      e = model(k, 1);
      checks++;
      if (o_str !== e.str) begin
        errors++;
        $display("FAIL ignore_strobes k=%0d got %b want %b", k, o_str, e.str);
      end
      if (o_str[0] === 1'b1) n_done++;
    end
    bus_a.start = 1'b0;
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d want 1", n_done);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   cut    = 1 + 7 * 67 + $urandom_range(2, 60);
    int   done_k = 0;
    sel_b = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= cut; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    checks++;
    if (o_str !== 7'd0 || o_wa !== 11'd0 || o_is !== 6'd0 || o_oa !== 5'd0) begin
      errors++;
      $display("FAIL abort_outputs got %b %0d %0d %0d want 0",
               o_str, o_wa, o_is, o_oa);
    end
`ifdef HL_SEQ_CYCLE_CNT_EN
    checks++;
    if (o_cc !== 16'd0) begin
      errors++;
      $display("FAIL abort_cycle_cnt got %0d want 0", o_cc);
    end
`endif
    repeat ($urandom_range(1, 4)) @(negedge clk);
    checks++;
    if (o_str !== 7'd0) begin
      errors++;
      $display("FAIL abort_no_done got %b want 0", o_str);
    end
    bus_a.start = 1'b1;
    for (int k = 1; k <= 1343; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      e = model(k, 1);
      checks++;
      if (o_str !== e.str) begin
        errors++;
        $display("FAIL abort_rerun k=%0d got %b want %b", k, o_str, e.str);
      end
      if (o_str[0] === 1'b1 && done_k == 0) done_k = k;
    end
    checks++;
    if (done_k != 1341) begin
      errors++;
      $display("FAIL abort_rerun_latency got %0d want 1341", done_k);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_done = 0;
    sel_b = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= 1342 + 1343; k++) begin
      @(negedge clk);
      if (k == 1343) bus_a.start = 1'b0;
      e = (k <= 1342) ? model(k, 1) : model(k - 1342, 1);
      checks++;
      if (o_str !== e.str) begin
        errors++;
        $display("FAIL b2b_strobes k=%0d got %b want %b", k, o_str, e.str);
      end
      if (o_str[0] === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 2", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_mem_lat3();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
